// File: rtl/punc_control.sv
// rtl/punc_control.sv - PUNC multi-cycle controller FSM; PUNC_HALT_EN enables TRAP->HALT
// Outputs are decoded combinationally from the current state and opcode.
module punc_control (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ir_to_controller,
   input  logic        nzp_true,
   output logic        pc_ld,
   output logic        pc_inc,
   output logic        pc_clr,
   output logic [1:0]  pc_sel,
   output logic        ir_ld,
   output logic        ir_clr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [1:0]  mem_r_addr_sel,
   output logic [1:0]  mem_w_addr_sel,
   output logic [1:0]  rf_w_data_sel,
   output logic        rf_w_addr_sel,
   output logic        rf_w_wr,
   output logic        rf_r0_rd,
   output logic        rf_r1_rd,
   output logic        rf_r0_addr_sel,
   output logic        prev_ld,
   output logic        nzp_ld,
   output logic        nzp_clr,
   output logic [1:0]  alu_sel,
   output logic        alu_first_val_sel,
   output logic        halted
);

   typedef enum logic [2:0] {
      S_INIT, S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_HALT
   } state_t;

   localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010,
                          OP_ST  = 4'b0011, OP_JSR = 4'b0100, OP_AND = 4'b0101,
                          OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001,
                          OP_LDI = 4'b1010, OP_STI = 4'b1011, OP_JMP = 4'b1100,
                          OP_LEA = 4'b1110, OP_TRAP = 4'b1111;

   state_t     state_q, state_d;
   logic [3:0] opcode;
   logic       unused_ir;

   assign opcode    = ir_to_controller[15:12];
   assign unused_ir = ^{ir_to_controller[10:6], ir_to_controller[4:0]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_INIT;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d           = state_q;
      pc_ld             = 1'b0;
      pc_inc            = 1'b0;
      pc_clr            = 1'b0;
      pc_sel            = 2'd0;
      ir_ld             = 1'b0;
      ir_clr            = 1'b0;
      mem_rd            = 1'b0;
      mem_wr            = 1'b0;
      mem_r_addr_sel    = 2'd0;
      mem_w_addr_sel    = 2'd0;
      rf_w_data_sel     = 2'd0;
      rf_w_addr_sel     = 1'b0;
      rf_w_wr           = 1'b0;
      rf_r0_rd          = 1'b0;
      rf_r1_rd          = 1'b0;
      rf_r0_addr_sel    = 1'b0;
      prev_ld           = 1'b0;
      nzp_ld            = 1'b0;
      nzp_clr           = 1'b0;
      alu_sel           = 2'd0;
      alu_first_val_sel = 1'b0;
      halted            = 1'b0;
      case (state_q)
         S_INIT: begin
            pc_clr  = 1'b1;
            ir_clr  = 1'b1;
            nzp_clr = 1'b1;
            state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_rd  = 1'b1;
            ir_ld   = 1'b1;
            pc_inc  = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            state_d = S_FETCH;
            case (opcode)
               OP_ADD, OP_AND: begin
                  // ir[5]=1 selects the immediate, else the second register via port 0
                  alu_sel           = (opcode == OP_ADD) ? 2'd1 : 2'd2;
                  alu_first_val_sel = ~ir_to_controller[5];
                  rf_r0_addr_sel    = ~ir_to_controller[5];
                  rf_r0_rd          = ~ir_to_controller[5];
                  rf_r1_rd          = 1'b1;
                  rf_w_addr_sel     = 1'b1;
                  rf_w_wr           = 1'b1;
                  nzp_ld            = 1'b1;
               end
               OP_NOT: begin
                  alu_sel       = 2'd3;
                  rf_r1_rd      = 1'b1;
                  rf_w_addr_sel = 1'b1;
                  rf_w_wr       = 1'b1;
                  nzp_ld        = 1'b1;
               end
               OP_LD, OP_LDR, OP_LDI: begin
                  mem_rd         = 1'b1;
                  mem_r_addr_sel = (opcode == OP_LDR) ? 2'd3 : 2'd1;
                  rf_r1_rd       = (opcode == OP_LDR);
                  rf_w_data_sel  = 2'd2;
                  rf_w_addr_sel  = 1'b1;
                  rf_w_wr        = 1'b1;
                  nzp_ld         = (opcode != OP_LDI);
                  if (opcode == OP_LDI) state_d = S_EXEC2;
               end
               OP_LEA: begin
                  rf_w_data_sel = 2'd1;
                  rf_w_addr_sel = 1'b1;
                  rf_w_wr       = 1'b1;
                  nzp_ld        = 1'b1;
               end
               OP_ST, OP_STR: begin
                  mem_wr         = 1'b1;
                  rf_r0_rd       = 1'b1;
                  mem_w_addr_sel = (opcode == OP_STR) ? 2'd2 : 2'd0;
                  rf_r1_rd       = (opcode == OP_STR);
               end
               OP_STI: begin
                  mem_rd         = 1'b1;
                  mem_r_addr_sel = 2'd1;
                  prev_ld        = 1'b1;
                  state_d        = S_EXEC2;
               end
               OP_BR: pc_ld = nzp_true;
               OP_JMP: begin
                  pc_ld    = 1'b1;
                  pc_sel   = 2'd2;
                  rf_r1_rd = 1'b1;
               end
               OP_JSR: begin
                  // R7 captures the already-incremented PC in the same cycle as the jump
                  rf_w_data_sel = 2'd3;
                  rf_w_wr       = 1'b1;
                  pc_ld         = 1'b1;
                  pc_sel        = ir_to_controller[11] ? 2'd1 : 2'd2;
                  rf_r1_rd      = ~ir_to_controller[11];
               end
`ifdef PUNC_HALT_EN
               OP_TRAP: state_d = S_HALT;
`endif
               default: ;
            endcase
         end
         S_EXEC2: begin
            state_d  = S_FETCH;
            rf_r0_rd = 1'b1;
            if (opcode == OP_STI) begin
               mem_wr         = 1'b1;
               mem_w_addr_sel = 2'd1;
            end else begin
               mem_rd         = 1'b1;
               mem_r_addr_sel = 2'd2;
               rf_w_data_sel  = 2'd2;
               rf_w_addr_sel  = 1'b1;
               rf_w_wr        = 1'b1;
               nzp_ld         = 1'b1;
            end
         end
         S_HALT: begin
`ifdef PUNC_HALT_EN
            halted = 1'b1;
`endif
         end
         default: state_d = S_INIT;
      endcase
   end

endmodule

// File: tb/tb_punc_control.sv
// tb/tb_punc_control.sv - randomized self-checking bench for punc_control against an opcode-table model
// Build with PUNC_HALT_EN defined to exercise TRAP->HALT.
module tb_punc_control;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ir;
   logic        nzp_true;
   logic        pc_ld, pc_inc, pc_clr, ir_ld, ir_clr, mem_rd, mem_wr;
   logic [1:0]  pc_sel, mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel, alu_sel;
   logic        rf_w_addr_sel, rf_w_wr, rf_r0_rd, rf_r1_rd, rf_r0_addr_sel;
   logic        prev_ld, nzp_ld, nzp_clr, alu_first_val_sel, halted;

   typedef struct packed {
      logic       pc_ld, pc_inc, pc_clr;
      logic [1:0] pc_sel;
      logic       ir_ld, ir_clr, mem_rd, mem_wr;
      logic [1:0] mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel;
      logic       rf_w_addr_sel, rf_w_wr, rf_r0_rd, rf_r1_rd, rf_r0_addr_sel;
      logic       prev_ld, nzp_ld, nzp_clr;
      logic [1:0] alu_sel;
      logic       alu_first_val_sel, halted;
   } out_t;

   localparam int PH_INIT = 0, PH_FETCH = 1, PH_DECODE = 2, PH_EXEC = 3, PH_EXEC2 = 4, PH_HALT = 5;

   out_t obs;
   int   checks = 0;
   int   errors = 0;

   assign obs = {pc_ld, pc_inc, pc_clr, pc_sel, ir_ld, ir_clr, mem_rd, mem_wr,
                 mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel, rf_w_addr_sel, rf_w_wr,
                 rf_r0_rd, rf_r1_rd, rf_r0_addr_sel, prev_ld, nzp_ld, nzp_clr,
                 alu_sel, alu_first_val_sel, halted};

   punc_control dut (
      .clk(clk), .rst(rst), .ir_to_controller(ir), .nzp_true(nzp_true),
      .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_clr(pc_clr), .pc_sel(pc_sel),
      .ir_ld(ir_ld), .ir_clr(ir_clr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_r_addr_sel(mem_r_addr_sel), .mem_w_addr_sel(mem_w_addr_sel),
      .rf_w_data_sel(rf_w_data_sel), .rf_w_addr_sel(rf_w_addr_sel), .rf_w_wr(rf_w_wr),
      .rf_r0_rd(rf_r0_rd), .rf_r1_rd(rf_r1_rd), .rf_r0_addr_sel(rf_r0_addr_sel),
      .prev_ld(prev_ld), .nzp_ld(nzp_ld), .nzp_clr(nzp_clr), .alu_sel(alu_sel),
      .alu_first_val_sel(alu_first_val_sel), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Register read enables are only pinned down where the store instructions name them.
   function automatic out_t care(int ph, logic [15:0] i);
      out_t m = '1;
      m.rf_r1_rd = 1'b0;
      if (!(ph == PH_EXEC && (i[15:12] == 4'h3 || i[15:12] == 4'h7))) m.rf_r0_rd = 1'b0;
      return m;
   endfunction

   // Expected strobes for one phase of an instruction, written opcode by opcode.
   function automatic out_t model(int ph, logic [15:0] i, logic nzp);
      out_t       e = '0;
      logic [3:0] op = i[15:12];
      if (ph == PH_INIT) begin
         e.pc_clr = 1; e.ir_clr = 1; e.nzp_clr = 1;
      end else if (ph == PH_FETCH) begin
         e.mem_rd = 1; e.ir_ld = 1; e.pc_inc = 1;
      end else if (ph == PH_HALT) begin
         e.halted = 1;
      end else if (ph == PH_EXEC) begin
         case (op)
            4'h1, 4'h5: begin
               e.alu_sel = (op == 4'h1) ? 2'd1 : 2'd2;
               e.alu_first_val_sel = ~i[5]; e.rf_r0_addr_sel = ~i[5];
               e.rf_w_wr = 1; e.rf_w_addr_sel = 1; e.nzp_ld = 1;
            end
            4'h9: begin e.alu_sel = 3; e.rf_w_wr = 1; e.rf_w_addr_sel = 1; e.nzp_ld = 1; end
            4'h2: begin e.mem_rd = 1; e.mem_r_addr_sel = 1; e.rf_w_data_sel = 2;
                        e.rf_w_wr = 1; e.rf_w_addr_sel = 1; e.nzp_ld = 1; end
            4'h6: begin e.mem_rd = 1; e.mem_r_addr_sel = 3; e.rf_w_data_sel = 2;
                        e.rf_w_wr = 1; e.rf_w_addr_sel = 1; e.nzp_ld = 1; end
            4'hE: begin e.rf_w_data_sel = 1; e.rf_w_wr = 1; e.rf_w_addr_sel = 1; e.nzp_ld = 1; end
            4'h3: begin e.mem_wr = 1; e.rf_r0_rd = 1; e.mem_w_addr_sel = 0; end
            4'h7: begin e.mem_wr = 1; e.rf_r0_rd = 1; e.mem_w_addr_sel = 2; end
            4'hA: begin e.mem_rd = 1; e.mem_r_addr_sel = 1; e.rf_w_data_sel = 2;
                        e.rf_w_wr = 1; e.rf_w_addr_sel = 1; end
            4'hB: begin e.mem_rd = 1; e.mem_r_addr_sel = 1; e.prev_ld = 1; end
            4'h0: e.pc_ld = nzp;
            4'hC: begin e.pc_ld = 1; e.pc_sel = 2; end
            4'h4: begin e.rf_w_wr = 1; e.rf_w_data_sel = 3; e.rf_w_addr_sel = 0;
                        e.pc_ld = 1; e.pc_sel = i[11] ? 2'd1 : 2'd2; end
            default: ;
         endcase
      end else if (ph == PH_EXEC2) begin
         if (op == 4'hA) begin
            e.mem_rd = 1; e.mem_r_addr_sel = 2; e.rf_w_data_sel = 2;
            e.rf_w_wr = 1; e.rf_w_addr_sel = 1; e.nzp_ld = 1;
         end else begin
            e.mem_wr = 1; e.mem_w_addr_sel = 1;
         end
      end
      return e;
   endfunction

   function automatic int instr_len(logic [15:0] i);
      return (i[15:12] == 4'hA || i[15:12] == 4'hB) ? 4 : 3;
   endfunction

   task automatic expect_phase(input string tag, input int ph, input logic [15:0] i, input logic nzp);
      out_t m = care(ph, i);
      check(tag, 32'(obs & m), 32'(model(ph, i, nzp) & m));
   endtask

   // Called #1 after the edge that enters FETCH; returns #1 after the edge entering the next FETCH.
   task automatic run_instr(input string name, input logic [15:0] i, input logic nzp);
      int cyc;
      expect_phase({name, "_fetch"}, PH_FETCH, i, nzp);
      @(posedge clk); #1;
      ir = i; nzp_true = nzp; #1;
      expect_phase({name, "_decode"}, PH_DECODE, i, nzp);
      @(posedge clk); #1;
      expect_phase({name, "_exec"}, PH_EXEC, i, nzp);
      cyc = 2;
      if (instr_len(i) == 4) begin
         @(posedge clk); #1;
         expect_phase({name, "_exec2"}, PH_EXEC2, i, nzp);
         cyc = 3;
      end
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!(ir_ld && pc_inc) && cyc < 8);
      check({name, "_len"}, 32'(cyc), 32'(instr_len(i)));
   endtask

   task automatic release_reset(input string name);
      @(posedge clk); #1;
      rst = 1'b1; #1;
      expect_phase({name, "_init"}, PH_INIT, 16'h0, 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [15:0] r;
      logic        n;
      rst = 1'b0; ir = 16'h0; nzp_true = 1'b0;
      #2;
      expect_phase("rst_async", PH_INIT, 16'h0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      expect_phase("rst_hold", PH_INIT, 16'h0, 1'b0);
      release_reset("boot");

      run_instr("add_imm", 16'h1261, 1'b0);
      run_instr("brz_taken", 16'h0402, 1'b1);
      run_instr("brz_not", 16'h0402, 1'b0);
      run_instr("sti", 16'hB005, 1'b0);
      run_instr("ldi", 16'hA3F0, 1'b0);
      run_instr("add_reg", 16'h1442, 1'b1);
      run_instr("jsr", 16'h4812, 1'b0);
      run_instr("jsrr", 16'h4080, 1'b0);
`ifndef PUNC_HALT_EN
      run_instr("trap_nop", 16'hF025, 1'b0);
`endif

      for (int k = 0; k < 60; k++) begin
         r = 16'($urandom);
         n = 1'($urandom);
`ifdef PUNC_HALT_EN
         if (r[15:12] == 4'hF) r[15:12] = 4'hD;
`endif
         run_instr($sformatf("rnd%0d", k), r, n);
      end

      // Reset pulsed mid-ST must kill the write at once.
      expect_phase("st_fetch", PH_FETCH, 16'h3200, 1'b0);
      @(posedge clk); #1;
      ir = 16'h3200; #1;
      @(posedge clk); #1;
      expect_phase("st_exec", PH_EXEC, 16'h3200, 1'b0);
      #2 rst = 1'b0; #1;
      expect_phase("st_abort", PH_INIT, 16'h3200, 1'b0);
      release_reset("st_rel");
      run_instr("after_abort", 16'h5020, 1'b1);

`ifdef PUNC_HALT_EN
      expect_phase("trap_fetch", PH_FETCH, 16'hF025, 1'b0);
      @(posedge clk); #1;
      ir = 16'hF025; #1;
      @(posedge clk); #1;
      expect_phase("trap_exec", PH_EXEC, 16'hF025, 1'b0);
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         expect_phase($sformatf("halt%0d", k), PH_HALT, 16'hF025, 1'b0);
      end
      rst = 1'b0; #1;
      expect_phase("halt_rst", PH_INIT, 16'hF025, 1'b0);
      release_reset("halt_rel");
      run_instr("post_halt", 16'h1261, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
